// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle control unit for the SCPU datapath.
//
// Sequences each MIPS instruction over 3..5 cycles (more with memory wait
// states) and drives the datapath mux selects and write enables so a single
// ALU and a single memory port can be shared across instruction phases.
//
// Ports:
//   clk, rst         rising-edge clock; synchronous active-high reset
//   Op, Funct        IR[31:26] / IR[5:0]; Op valid from S_ID onward
//   Zero             ALU zero flag, used combinationally in S_BR
//   mem_ready        memory done; only used when MC_MEMWAIT_EN is defined
//   PCWrite, NPCOp   PC load enable and next-PC select
//   IRWrite          IR load enable
//   MemRead/MemWrite data-memory strobes
//   RegWrite         register-file write enable
//   RegDst, ALUSrc, ToReg, ALUOp   datapath selects
//   state            current state code (debug / checker hook)
//   illegal          one-cycle pulse in S_ID for an undecoded opcode
//
// Optional feature macro: MC_MEMWAIT_EN. When defined, S_IF, S_MR and S_MW
// stall while mem_ready=0. When undefined, mem_ready is ignored.
//
// Select encodings normally come from ctrl_encode_def.v; the fallback values
// below are only used when that header has not defined them already.

`ifndef RD_RT
`define RD_RT       2'b00
`endif
`ifndef RD_RD
`define RD_RD       2'b01
`endif
`ifndef RD_RA
`define RD_RA       2'b10
`endif
`ifndef ALUSRC_REG
`define ALUSRC_REG  2'b00
`endif
`ifndef ALUSRC_IMM
`define ALUSRC_IMM  2'b01
`endif
`ifndef ALUSRC_SHA
`define ALUSRC_SHA  2'b10
`endif
`ifndef ALUSRC_ZERO
`define ALUSRC_ZERO 2'b11
`endif
`ifndef ALU2REG
`define ALU2REG     2'b00
`endif
`ifndef DM2REG
`define DM2REG      2'b01
`endif
`ifndef NPC2REG
`define NPC2REG     2'b10
`endif
`ifndef NPC_PLUS4
`define NPC_PLUS4   2'b00
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH  2'b01
`endif
`ifndef NPC_JUMP
`define NPC_JUMP    2'b10
`endif
`ifndef NPC_JR
`define NPC_JR      2'b11
`endif
`ifndef ALU_NOP
`define ALU_NOP     4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD     4'd1
`endif
`ifndef ALU_SUB
`define ALU_SUB     4'd2
`endif
`ifndef ALU_AND
`define ALU_AND     4'd3
`endif
`ifndef ALU_OR
`define ALU_OR      4'd4
`endif
`ifndef ALU_SLT
`define ALU_SLT     4'd5
`endif
`ifndef ALU_SLL
`define ALU_SLL     4'd6
`endif
`ifndef ALU_SRL
`define ALU_SRL     4'd7
`endif
`ifndef ALU_LUI
`define ALU_LUI     4'd8
`endif

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrc,
    output logic [1:0] ToReg,
    output logic [3:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXI = 4'd3, S_MA = 4'd4,
        S_MR  = 4'd5, S_MW = 4'd6, S_WB  = 4'd7, S_BR  = 4'd8, S_J  = 4'd9
    } state_t;

    state_t state_q, state_d;

    // Instruction class decode from the IR fields.
    logic is_r, is_jr, is_shift, is_lw, is_sw, is_itype, is_beq, is_bne, is_j, is_jal;
    assign is_r     = (Op == 6'b000000);
    assign is_jr    = is_r && (Funct == 6'b001000);
    assign is_shift = is_r && ((Funct == 6'b000000) || (Funct == 6'b000010));
    assign is_lw    = (Op == 6'b100011);
    assign is_sw    = (Op == 6'b101011);
    assign is_itype = (Op == 6'b001000) || (Op == 6'b001101) || (Op == 6'b001111);
    assign is_beq   = (Op == 6'b000100);
    assign is_bne   = (Op == 6'b000101);
    assign is_j     = (Op == 6'b000010);
    assign is_jal   = (Op == 6'b000011);

    logic mem_go;
`ifdef MC_MEMWAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    // Raw strobes before reset gating.
    logic pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, ill;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_wr  = 1'b0;
        ill     = 1'b0;
        NPCOp   = `NPC_PLUS4;
        RegDst  = `RD_RT;
        ALUSrc  = `ALUSRC_REG;
        ToReg   = `ALU2REG;
        ALUOp   = `ALU_NOP;
        case (state_q)
            S_IF: begin
                // PC and IR load together so Op is valid in S_ID.
                ir_wr   = mem_go;
                pc_wr   = mem_go;
                state_d = mem_go ? S_ID : S_IF;
            end
            S_ID: begin
                if (is_jr)                 state_d = S_J;
                else if (is_r)             state_d = S_EXR;
                else if (is_itype)         state_d = S_EXI;
                else if (is_lw || is_sw)   state_d = S_MA;
                else if (is_beq || is_bne) state_d = S_BR;
                else if (is_j || is_jal)   state_d = S_J;
                else begin
                    ill     = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXR: begin
                ALUSrc = is_shift ? `ALUSRC_SHA : `ALUSRC_REG;
                case (Funct)
                    6'b100000: ALUOp = `ALU_ADD;
                    6'b100010: ALUOp = `ALU_SUB;
                    6'b100100: ALUOp = `ALU_AND;
                    6'b100101: ALUOp = `ALU_OR;
                    6'b101010: ALUOp = `ALU_SLT;
                    6'b000000: ALUOp = `ALU_SLL;
                    6'b000010: ALUOp = `ALU_SRL;
                    default:   ALUOp = `ALU_NOP;
                endcase
                state_d = S_WB;
            end
            S_EXI: begin
                ALUSrc = `ALUSRC_IMM;
                case (Op)
                    6'b001000: ALUOp = `ALU_ADD;
                    6'b001101: ALUOp = `ALU_OR;
                    6'b001111: ALUOp = `ALU_LUI;
                    default:   ALUOp = `ALU_NOP;
                endcase
                state_d = S_WB;
            end
            S_MA: begin
                ALUSrc  = `ALUSRC_IMM;
                ALUOp   = `ALU_ADD;
                state_d = is_lw ? S_MR : S_MW;
            end
            S_MR: begin
                mem_rd  = 1'b1;
                state_d = mem_go ? S_WB : S_MR;
            end
            S_MW: begin
                mem_wr  = 1'b1;
                state_d = mem_go ? S_IF : S_MW;
            end
            S_WB: begin
                reg_wr = 1'b1;
                if (is_lw) begin
                    RegDst = `RD_RT;
                    ToReg  = `DM2REG;
                end else if (is_r) begin
                    RegDst = `RD_RD;
                    ToReg  = `ALU2REG;
                end else begin
                    RegDst = `RD_RT;
                    ToReg  = `ALU2REG;
                end
                state_d = S_IF;
            end
            S_BR: begin
                ALUSrc  = `ALUSRC_REG;
                ALUOp   = `ALU_SUB;
                NPCOp   = `NPC_BRANCH;
                pc_wr   = (is_beq && Zero) || (is_bne && !Zero);
                state_d = S_IF;
            end
            S_J: begin
                pc_wr = 1'b1;
                NPCOp = is_jr ? `NPC_JR : `NPC_JUMP;
                if (is_jal) begin
                    reg_wr = 1'b1;
                    RegDst = `RD_RA;
                    ToReg  = `NPC2REG;
                end
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Reset suppresses every strobe in the same cycle, so an aborted
    // instruction never issues a partial write.
    assign PCWrite  = pc_wr  & ~rst;
    assign IRWrite  = ir_wr  & ~rst;
    assign MemRead  = mem_rd & ~rst;
    assign MemWrite = mem_wr & ~rst;
    assign RegWrite = reg_wr & ~rst;
    assign illegal  = ill    & ~rst;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  // Encodings as expected from ctrl_encode_def.v
  localparam logic [1:0] E_RD_RT = 2'b00, E_RD_RD = 2'b01, E_RD_RA = 2'b10;
  localparam logic [1:0] E_SRC_REG = 2'b00, E_SRC_IMM = 2'b01, E_SRC_SHA = 2'b10;
  localparam logic [1:0] E_ALU2REG = 2'b00, E_DM2REG = 2'b01, E_NPC2REG = 2'b10;
  localparam logic [1:0] E_PLUS4 = 2'b00, E_BRANCH = 2'b01, E_JUMP = 2'b10, E_JR = 2'b11;
  localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_LUI = 4'd8;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                         OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000,
                         F_SRL = 6'b000010, F_JR = 6'b001000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, illegal;
  logic [1:0] npc_op, reg_dst, alu_src, to_reg;
  logic [3:0] alu_op, state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero), .mem_ready(mem_ready),
    .PCWrite(pc_write), .NPCOp(npc_op), .IRWrite(ir_write), .MemRead(mem_read),
    .MemWrite(mem_write), .RegWrite(reg_write), .RegDst(reg_dst), .ALUSrc(alu_src),
    .ToReg(to_reg), .ALUOp(alu_op), .state(state), .illegal(illegal)
  );

  // scoreboard: one entry per expected cycle
  // vector = {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal,
  //           NPCOp, RegDst, ALUSrc, ToReg, ALUOp}
  logic [21:0] exp_q[$];
  logic [21:0] mask_q[$];
  string       tag_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // care = {npc, regdst, alusrc, toreg, aluop}; state and strobes always checked
  task automatic push(input string tag, input logic [3:0] st, input logic [5:0] stb,
                      input logic [1:0] npc, input logic [1:0] rd, input logic [1:0] src,
                      input logic [1:0] tr, input logic [3:0] aop, input logic [4:0] care);
    exp_q.push_back({st, stb, npc, rd, src, tr, aop});
    mask_q.push_back({4'hF, 6'h3F, {2{care[4]}}, {2{care[3]}}, {2{care[2]}},
                      {2{care[1]}}, {4{care[0]}}});
    tag_q.push_back(tag);
  endtask

  // Compare one cycle at the falling edge, then advance past the next rising edge.
  task automatic drain_one();
    logic [21:0] e, m, obs;
    string t;
    @(negedge clk);
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    t = tag_q.pop_front();
    obs = {state, pc_write, ir_write, mem_read, mem_write, reg_write, illegal,
           npc_op, reg_dst, alu_src, to_reg, alu_op};
    check_eq(t, obs & m, e & m);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) drain_one();
  endtask

  // Expected per-cycle behaviour of one instruction, derived from the ISA rules.
  task automatic expect_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    logic r;
    logic [3:0] aop;
    r = (o == OP_R);
    push("if", 4'd0, 6'b110000, E_PLUS4, 2'd0, 2'd0, 2'd0, 4'd0, 5'b10000);
    if (r && f == F_JR) begin
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("jr", 4'd9, 6'b100000, E_JR, 2'd0, 2'd0, 2'd0, 4'd0, 5'b10000);
    end else if (r) begin
      case (f)
        F_ADD: aop = A_ADD;
        F_SUB: aop = A_SUB;
        F_AND: aop = A_AND;
        F_OR:  aop = A_OR;
        F_SLT: aop = A_SLT;
        F_SLL: aop = A_SLL;
        default: aop = A_SRL;
      endcase
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("exr", 4'd2, 6'b000000, 2'd0, 2'd0,
           (f == F_SLL || f == F_SRL) ? E_SRC_SHA : E_SRC_REG, 2'd0, aop, 5'b00101);
      push("wb_r", 4'd7, 6'b000010, 2'd0, E_RD_RD, 2'd0, E_ALU2REG, 4'd0, 5'b01010);
    end else if (o == OP_ADDI || o == OP_ORI || o == OP_LUI) begin
      aop = (o == OP_ADDI) ? A_ADD : (o == OP_ORI) ? A_OR : A_LUI;
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("exi", 4'd3, 6'b000000, 2'd0, 2'd0, E_SRC_IMM, 2'd0, aop, 5'b00101);
      push("wb_i", 4'd7, 6'b000010, 2'd0, E_RD_RT, 2'd0, E_ALU2REG, 4'd0, 5'b01010);
    end else if (o == OP_LW || o == OP_SW) begin
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("ma", 4'd4, 6'b000000, 2'd0, 2'd0, E_SRC_IMM, 2'd0, A_ADD, 5'b00101);
      if (o == OP_LW) begin
        push("mr", 4'd5, 6'b001000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
        push("wb_lw", 4'd7, 6'b000010, 2'd0, E_RD_RT, 2'd0, E_DM2REG, 4'd0, 5'b01010);
      end else begin
        push("mw", 4'd6, 6'b000100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      end
    end else if (o == OP_BEQ || o == OP_BNE) begin
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("br", 4'd8, {((o == OP_BEQ) ? z : !z), 5'b00000}, E_BRANCH, 2'd0,
           E_SRC_REG, 2'd0, A_SUB, 5'b10101);
    end else if (o == OP_J) begin
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("j", 4'd9, 6'b100000, E_JUMP, 2'd0, 2'd0, 2'd0, 4'd0, 5'b10000);
    end else if (o == OP_JAL) begin
      push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      push("jal", 4'd9, 6'b100010, E_JUMP, E_RD_RA, 2'd0, E_NPC2REG, 4'd0, 5'b11010);
    end else begin
      push("id_illegal", 4'd1, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    end
  endtask

  // driver: apply IR fields / Zero and check the whole instruction
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o;
    funct = f;
    zero = z;
    expect_instr(o, f, z);
    drain_all();
  endtask

  logic [5:0] tbl_op[16];
  logic [5:0] tbl_fn[16];

  initial begin
    tbl_op = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_ADDI, OP_ORI,
               OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL};
    tbl_fn = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR, 6'd0, 6'd0,
               6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    // reset held for 3 cycles: state 0, all strobes low
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push("reset", 4'd0, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
      @(negedge clk);
      begin
        logic [21:0] e, m;
        string t;
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {state, pc_write, ir_write, mem_read, mem_write, reg_write, illegal,
                     npc_op, reg_dst, alu_src, to_reg, alu_op} & m, e & m);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed: first instruction after reset checks the S_IF strobes
    run_instr(OP_R, F_ADD, 1'b0);
    run_instr(OP_LW, 6'd0, 1'b0);
    run_instr(OP_BEQ, 6'd0, 1'b1);
    run_instr(OP_BEQ, 6'd0, 1'b0);
    run_instr(OP_BNE, 6'd0, 1'b1);
    run_instr(OP_BNE, 6'd0, 1'b0);
    run_instr(OP_JAL, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0);
    run_instr(OP_J, 6'd0, 1'b0);
    run_instr(OP_R, F_JR, 1'b0);
    run_instr(OP_R, F_SLL, 1'b0);
    run_instr(OP_R, F_SRL, 1'b0);
    run_instr(OP_ADDI, 6'd0, 1'b0);
    run_instr(OP_LUI, 6'd0, 1'b0);
    run_instr(OP_SW, 6'd0, 1'b0);
    run_instr(6'b010000, 6'd0, 1'b0);

    // reset in S_WB aborts the register write
    op = OP_R;
    funct = F_OR;
    push("if", 4'd0, 6'b110000, E_PLUS4, 2'd0, 2'd0, 2'd0, 4'd0, 5'b10000);
    push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    push("exr", 4'd2, 6'b000000, 2'd0, 2'd0, E_SRC_REG, 2'd0, A_OR, 5'b00101);
    drain_all();
    rst = 1'b1;
    push("wb_abort", 4'd7, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    push("reset_if", 4'd0, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    rst = 1'b0;
    run_instr(OP_R, F_OR, 1'b0);

`ifdef MC_MEMWAIT_EN
    // sw with a two-cycle memory stall in S_MW
    op = OP_SW;
    push("if", 4'd0, 6'b110000, E_PLUS4, 2'd0, 2'd0, 2'd0, 4'd0, 5'b10000);
    push("id", 4'd1, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    push("ma", 4'd4, 6'b000000, 2'd0, 2'd0, E_SRC_IMM, 2'd0, A_ADD, 5'b00101);
    drain_all();
    mem_ready = 1'b0;
    push("mw_wait1", 4'd6, 6'b000100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    push("mw_wait2", 4'd6, 6'b000100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    mem_ready = 1'b1;
    push("mw_done", 4'd6, 6'b000100, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    // fetch stall: no PC/IR load until memory is ready
    mem_ready = 1'b0;
    push("if_wait", 4'd0, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 5'b00000);
    drain_one();
    mem_ready = 1'b1;
    run_instr(OP_R, F_ADD, 1'b0);
`endif

    // random instruction stream
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 15);
`ifndef MC_MEMWAIT_EN
      mem_ready = 1'($urandom_range(0, 1));
`endif
      run_instr(tbl_op[k], tbl_fn[k], 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
